// File: rtl/peak_track.sv
`default_nettype none
// ============================================================================
// Module   : peak_track
// Purpose  : Streaming per-window FFT peak search with left/centre/right
//            power capture and a backpressured result stream.
// Revision : 1.0  initial release
// ============================================================================
module peak_track #(
    parameter int BATCH_SIZE = 1024,
    parameter int DATA_WIDTH = 20,
    parameter int NPEAKS     = 4,
    parameter int PEAK_FIRST = 200,
    parameter int PEAK_STEP  = 200,
    parameter int PEAKDEV    = 50,
    parameter int ADDR_WIDTH = $clog2(BATCH_SIZE),
    parameter int MAG_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [MAG_WIDTH-1:0]  threshold,
    input  logic                  sink_valid,
    output logic                  sink_ready,
    input  logic                  sink_sop,
    input  logic                  sink_eop,
    input  logic [DATA_WIDTH-1:0] sink_re,
    input  logic [DATA_WIDTH-1:0] sink_im,
    output logic                  source_valid,
    input  logic                  source_ready,
    output logic                  source_sop,
    output logic                  source_eop,
    output logic                  source_found,
    output logic [ADDR_WIDTH-1:0] source_bin,
    output logic [MAG_WIDTH-1:0]  source_mag_l,
    output logic [MAG_WIDTH-1:0]  source_mag_c,
    output logic [MAG_WIDTH-1:0]  source_mag_r,
    output logic                  batch_err
);

    localparam int OIDX_W = (NPEAKS > 1) ? $clog2(NPEAKS) : 1;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_BIN = ADDR_WIDTH'(BATCH_SIZE - 1);
    localparam logic [OIDX_W-1:0]     c_LAST_WIN = OIDX_W'(NPEAKS - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_COLLECT = 2'd1;
    localparam logic [1:0] c_DRAIN   = 2'd2;
    localparam logic [1:0] c_OUTPUT  = 2'd3;

    generate
        if (PEAK_STEP < 2 * PEAKDEV) begin : g_bad_spacing
            $error("peak_track: PEAK_STEP must be at least 2*PEAKDEV");
        end
    endgenerate

    function automatic int win_lo(input int k);
        int v;
        v = PEAK_FIRST + k * PEAK_STEP - PEAKDEV;
        return (v < 0) ? 0 : v;
    endfunction

    function automatic int win_hi(input int k);
        int v;
        v = PEAK_FIRST + k * PEAK_STEP + PEAKDEV - 1;
        return (v > BATCH_SIZE - 1) ? BATCH_SIZE - 1 : v;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] win_centre(input int k);
        return ADDR_WIDTH'(PEAK_FIRST + k * PEAK_STEP);
    endfunction

    logic [1:0]            r_state;
    logic [1:0]            w_state_d;
    logic                  r_sink_ready;
    logic                  r_batch_err;
    logic                  r_drain;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [MAG_WIDTH-1:0]  r_thresh;
    logic [OIDX_W-1:0]     r_out_idx;

    logic                  r_s1_vld;
    logic [MAG_WIDTH-1:0]  r_s1_pow;
    logic [ADDR_WIDTH-1:0] r_s1_idx;
    logic [MAG_WIDTH-1:0]  r_prev_pow;

    logic [MAG_WIDTH-1:0]  r_max  [NPEAKS];
    logic [ADDR_WIDTH-1:0] r_bin  [NPEAKS];
    logic [MAG_WIDTH-1:0]  r_ml   [NPEAKS];
    logic [MAG_WIDTH-1:0]  r_mr   [NPEAKS];
    logic [NPEAKS-1:0]     r_pend;
    logic [NPEAKS-1:0]     w_in_win;

    logic                  r_src_valid, r_src_sop, r_src_eop, r_src_found;
    logic [ADDR_WIDTH-1:0] r_src_bin;
    logic [MAG_WIDTH-1:0]  r_src_ml, r_src_mc, r_src_mr;

    logic signed [MAG_WIDTH-1:0] w_re_ext, w_im_ext;
    logic [MAG_WIDTH-1:0]  w_pow;
    logic [MAG_WIDTH-1:0]  w_prev_pow;
    logic                  w_accept, w_start, w_s1_load, w_last, w_err, w_load;
    logic [ADDR_WIDTH-1:0] w_beat_idx;
    logic [OIDX_W-1:0]     w_sel;

    // Sign-extend before squaring so the low MAG_WIDTH bits hold the exact power.
    assign w_re_ext = MAG_WIDTH'($signed(sink_re));
    assign w_im_ext = MAG_WIDTH'($signed(sink_im));
    assign w_pow    = $unsigned(w_re_ext * w_re_ext) + $unsigned(w_im_ext * w_im_ext);

    assign w_accept   = sink_valid && r_sink_ready;
    assign w_start    = w_accept && sink_sop;
    assign w_s1_load  = w_accept && (sink_sop || (r_state == c_COLLECT));
    assign w_beat_idx = sink_sop ? '0 : r_idx;
    assign w_last     = (w_beat_idx == c_LAST_BIN);
    assign w_prev_pow = (r_s1_idx == '0) ? '0 : r_prev_pow;

    always_comb begin
        w_state_d = r_state;
        w_err     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_start) begin
                    if (sink_eop != w_last) begin
                        w_err     = 1'b1;
                        w_state_d = c_IDLE;
                    end else if (sink_eop) begin
                        w_state_d = c_DRAIN;
                    end else begin
                        w_state_d = c_COLLECT;
                    end
                end
            end
            c_COLLECT: begin
                if (w_accept) begin
                    if (sink_sop) begin
                        w_err     = 1'b1;
                        w_state_d = c_COLLECT;
                    end else if (sink_eop != w_last) begin
                        w_err     = 1'b1;
                        w_state_d = c_IDLE;
                    end else if (sink_eop) begin
                        w_state_d = c_DRAIN;
                    end
                end
            end
            c_DRAIN: begin
                if (r_drain) w_state_d = c_OUTPUT;
            end
            c_OUTPUT: begin
                if (r_src_valid && source_ready && r_src_eop) w_state_d = c_IDLE;
            end
            default: w_state_d = c_IDLE;
        endcase
    end

    always_comb begin
        w_in_win = '0;
        for (int k = 0; k < NPEAKS; k++) begin
            w_in_win[k] = (int'(r_s1_idx) >= win_lo(k)) && (int'(r_s1_idx) <= win_hi(k));
        end
    end

    // Loading window 0 at the end of the second drain cycle, or the next window on consumption.
    assign w_load = ((r_state == c_DRAIN) && r_drain) ||
                    ((r_state == c_OUTPUT) && r_src_valid && source_ready && !r_src_eop);
    assign w_sel  = (r_state == c_DRAIN) ? '0 : r_out_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_sink_ready <= 1'b0;
            r_batch_err  <= 1'b0;
            r_drain      <= 1'b0;
            r_idx        <= '0;
            r_thresh     <= '0;
            r_out_idx    <= '0;
            r_src_valid  <= 1'b0;
            r_src_sop    <= 1'b0;
            r_src_eop    <= 1'b0;
            r_src_found  <= 1'b0;
            r_src_bin    <= '0;
            r_src_ml     <= '0;
            r_src_mc     <= '0;
            r_src_mr     <= '0;
        end else begin
            r_state      <= w_state_d;
            r_sink_ready <= (w_state_d == c_IDLE) || (w_state_d == c_COLLECT);
            r_batch_err  <= w_err;
            r_drain      <= (r_state == c_DRAIN) && !r_drain;
            if (w_s1_load) r_idx <= w_beat_idx + 1'b1;
            if (w_start) r_thresh <= threshold;
            if (w_load) begin
                r_out_idx   <= w_sel;
                r_src_valid <= 1'b1;
                r_src_sop   <= (w_sel == '0);
                r_src_eop   <= (w_sel == c_LAST_WIN);
                r_src_found <= (r_max[w_sel] >= r_thresh) && (r_max[w_sel] != '0);
                r_src_bin   <= r_bin[w_sel];
                r_src_ml    <= r_ml[w_sel];
                r_src_mc    <= r_max[w_sel];
                r_src_mr    <= r_mr[w_sel];
            end else if (r_src_valid && source_ready) begin
                r_src_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_vld   <= 1'b0;
            r_s1_pow   <= '0;
            r_s1_idx   <= '0;
            r_prev_pow <= '0;
        end else begin
            r_s1_vld <= w_s1_load;
            if (w_s1_load) begin
                r_s1_pow <= w_pow;
                r_s1_idx <= w_beat_idx;
            end
            if (r_s1_vld) r_prev_pow <= r_s1_pow;
        end
    end

    // A new maximum overrides a same-cycle right-neighbour capture and re-arms it.
    always_ff @(posedge clk) begin
        if (reset || w_start) begin
            for (int k = 0; k < NPEAKS; k++) begin
                r_max[k]  <= '0;
                r_bin[k]  <= win_centre(k);
                r_ml[k]   <= '0;
                r_mr[k]   <= '0;
                r_pend[k] <= 1'b0;
            end
        end else if (r_s1_vld) begin
            for (int k = 0; k < NPEAKS; k++) begin
                if (r_pend[k]) begin
                    r_mr[k]   <= r_s1_pow;
                    r_pend[k] <= 1'b0;
                end
                if (w_in_win[k] && (r_s1_pow > r_max[k])) begin
                    r_max[k]  <= r_s1_pow;
                    r_bin[k]  <= r_s1_idx;
                    r_ml[k]   <= w_prev_pow;
                    r_mr[k]   <= '0;
                    r_pend[k] <= 1'b1;
                end
            end
        end
    end

    assign sink_ready   = r_sink_ready;
    assign batch_err    = r_batch_err;
    assign source_valid = r_src_valid;
    assign source_sop   = r_src_sop;
    assign source_eop   = r_src_eop;
    assign source_found = r_src_found;
    assign source_bin   = r_src_bin;
    assign source_mag_l = r_src_ml;
    assign source_mag_c = r_src_mc;
    assign source_mag_r = r_src_mr;

endmodule
`default_nettype wire
